// File: rtl/lte_cc_tailbite_feeder.sv
// Tail-biting feeder for the LTE convolutional encoder: buffers one code block,
// pulses load with the last six bits, then replays the block gap-free.
module lte_cc_tailbite_feeder #(
    parameter int MAX_BLOCK = 2048,
    parameter int GAP       = 5,
    parameter int CNT_W     = $clog2(MAX_BLOCK + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_bit,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [5:0] init_word,
    output logic       load,
    output logic       din,
    output logic       din_valid,
    output logic       din_last,
    output logic       busy,
    output logic       err_short,
    output logic       err_ovf
);
    localparam int AW = (MAX_BLOCK > 1) ? $clog2(MAX_BLOCK) : 1;
    localparam logic [CNT_W-1:0] K_MAX = CNT_W'(MAX_BLOCK);
    localparam logic [CNT_W-1:0] K_MIN = CNT_W'(6);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [3:0] GAP_LAST    = 4'(GAP - 1);

    typedef enum logic [1:0] {S_FILL, S_LOAD, S_GAP, S_PLAY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] wr_nxt;
    logic [3:0]       gap_q, gap_d;
    logic [5:0]       tail_q, tail_d;
    logic [5:0]       init_q, init_d;
    logic             load_q, load_d;
    logic             dv_q, dv_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             short_q, short_d;
    logic             ovf_q, ovf_d;
    logic             din_q;
    logic             take;
    logic             rd_en;
    logic [AW-1:0]    mem_addr;
    logic             mem [0:MAX_BLOCK-1];

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        k_d      = k_q;
        gap_d    = gap_q;
        tail_d   = tail_q;
        init_d   = init_q;
        load_d   = 1'b0;
        dv_d     = 1'b0;
        last_d   = 1'b0;
        short_d  = 1'b0;
        ovf_d    = 1'b0;
        rd_en    = 1'b0;
        s_ready  = (state_q == S_FILL);
        take     = s_ready && s_valid;
        wr_nxt   = wr_cnt_q + ONE;
        unique case (state_q)
            S_FILL: begin
                if (take) begin
                    tail_d   = {s_bit, tail_q[5:1]};
                    wr_cnt_d = wr_nxt;
                    if (s_last && (wr_nxt < K_MIN)) begin
                        short_d  = 1'b1;
                        wr_cnt_d = '0;
                    end else if (s_last || (wr_nxt == K_MAX)) begin
                        ovf_d    = !s_last;
                        k_d      = wr_nxt;
                        init_d   = {s_bit, tail_q[5:1]};
                        load_d   = 1'b1;
                        wr_cnt_d = '0;
                        state_d  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                rd_cnt_d = '0;
                gap_d    = '0;
                state_d  = S_GAP;
            end
            S_GAP: begin
                gap_d = gap_q + 4'd1;
                if (gap_q == GAP_LAST) begin
                    rd_en   = 1'b1;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                // rd_cnt runs one ahead of the bit on din because of the RAM latency
                rd_en = (rd_cnt_q != k_q);
                if (last_q) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + ONE;
            dv_d     = 1'b1;
            last_d   = (rd_cnt_q == (k_q - ONE));
        end
        mem_addr = (state_q == S_FILL) ? wr_cnt_q[AW-1:0]
                                       : rd_cnt_q[AW-1:0];
        busy_d   = (state_d != S_FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FILL;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            k_q      <= '0;
            gap_q    <= '0;
            tail_q   <= '0;
            init_q   <= '0;
            load_q   <= 1'b0;
            dv_q     <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            short_q  <= 1'b0;
            ovf_q    <= 1'b0;
            din_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            k_q      <= k_d;
            gap_q    <= gap_d;
            tail_q   <= tail_d;
            init_q   <= init_d;
            load_q   <= load_d;
            dv_q     <= dv_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            short_q  <= short_d;
            ovf_q    <= ovf_d;
            if (rd_en) begin
                din_q <= mem[mem_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            mem[mem_addr] <= s_bit;
        end
    end

    assign init_word = init_q;
    assign load      = load_q;
    assign din       = din_q;
    assign din_valid = dv_q;
    assign din_last  = last_q;
    assign busy      = busy_q;
    assign err_short = short_q;
    assign err_ovf   = ovf_q;
endmodule

// File: tb/tb_lte_cc_tailbite_feeder.sv
// Bench for lte_cc_tailbite_feeder: directed block table, back-to-back,
// reset-in-replay and random traffic against a block-level latency model.
module tb_lte_cc_tailbite_feeder;
    localparam int MAXB = 64;
    localparam int GAPC = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_bit = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [5:0] init_word;
    logic       load, din, din_valid, din_last, busy, err_short, err_ovf;

    lte_cc_tailbite_feeder #(.MAX_BLOCK(MAXB), .GAP(GAPC)) dut (
        .clk(clk), .rst(rst), .s_bit(s_bit), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .init_word(init_word),
        .load(load), .din(din), .din_valid(din_valid),
        .din_last(din_last), .busy(busy), .err_short(err_short),
        .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit b;
        bit l;
    } item_t;

    typedef struct {
        int          k;
        logic [63:0] bits;
        bit          nolast;
        logic [5:0]  init;
        int          loads;
        int          shorts;
        int          ovfs;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit armed = 0;
    int vprob = 100;

    bit         e_dv[int];
    bit         e_din[int];
    bit         e_last[int];
    bit         e_load[int];
    bit         e_short[int];
    bit         e_ovf[int];
    logic [5:0] e_init_at[int];
    logic [5:0] cur_init = '0;
    int next_free = 0;
    int busy_lo = 1;
    int busy_hi = 0;
    int prev_end = -1;
    int last_gap = -1;
    int play_start = -1;
    bit    blk[$];
    item_t pend[$];

    int n_load = 0, n_short = 0, n_ovf = 0, n_last = 0;
    logic [5:0] last_init = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        e_dv.delete(); e_din.delete(); e_last.delete();
        e_load.delete(); e_short.delete(); e_ovf.delete();
        e_init_at.delete();
        e_init_at[cyc + 1] = '0;
        next_free = cyc + 1;
        busy_lo = 1;
        busy_hi = 0;
        prev_end = -1;
        blk.delete();
    endtask

    task automatic model_accept(input bit b, input bit l);
        int k;
        logic [5:0] w;
        if (blk.size() == 0 && prev_end >= 0) last_gap = cyc - prev_end;
        blk.push_back(b);
        if (l || blk.size() == MAXB) begin
            k = blk.size();
            if (l && k < 6) begin
                e_short[cyc + 1] = 1'b1;
            end else begin
                if (!l) e_ovf[cyc + 1] = 1'b1;
                for (int i = 0; i < 6; i++) w[i] = blk[k - 6 + i];
                e_load[cyc + 1] = 1'b1;
                e_init_at[cyc + 1] = w;
                busy_lo = cyc + 1;
                busy_hi = cyc + 1 + GAPC + k;
                play_start = cyc + 2 + GAPC;
                for (int i = 0; i < k; i++) begin
                    e_dv[play_start + i] = 1'b1;
                    e_din[play_start + i] = blk[i];
                end
                e_last[play_start + k - 1] = 1'b1;
                next_free = cyc + 2 + GAPC + k;
                prev_end = cyc;
            end
            blk.delete();
        end
    endtask

    task automatic step(input bit r);
        bit dv_exp;
        bit acc;
        @(negedge clk);
        if (armed) begin
            if (e_init_at.exists(cyc)) cur_init = e_init_at[cyc];
            dv_exp = e_dv.exists(cyc);
            chk("s_ready", 32'(s_ready), 32'(cyc >= next_free));
            chk("load", 32'(load), 32'(e_load.exists(cyc)));
            chk("init_word", 32'(init_word), 32'(cur_init));
            chk("din_valid", 32'(din_valid), 32'(dv_exp));
            chk("din_last", 32'(din_last), 32'(e_last.exists(cyc)));
            chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
            chk("err_short", 32'(err_short), 32'(e_short.exists(cyc)));
            chk("err_ovf", 32'(err_ovf), 32'(e_ovf.exists(cyc)));
            if (dv_exp) chk("din", 32'(din), 32'(e_din[cyc]));
            if (load) begin
                n_load++;
                last_init = init_word;
            end
            if (err_short) n_short++;
            if (err_ovf) n_ovf++;
            if (din_last) n_last++;
        end
        rst = r;
        s_valid = 1'b0;
        s_bit = 1'b0;
        s_last = 1'b0;
        if (!r && pend.size() > 0 && $urandom_range(99) < vprob) begin
            s_valid = 1'b1;
            s_bit = pend[0].b;
            s_last = pend[0].l;
        end
        acc = !r && s_valid && (cyc >= next_free);
        if (r) begin
            model_reset();
        end else if (acc) begin
            void'(pend.pop_front());
            model_accept(s_bit, s_last);
        end
        cyc++;
    endtask

    task automatic push_bit(input bit b, input bit l);
        item_t it;
        it.b = b;
        it.l = l;
        pend.push_back(it);
    endtask

    task automatic push_blk(input int k, input logic [63:0] bits,
                            input bit nolast);
        for (int i = 0; i < k; i++) push_bit(bits[i], !nolast && i == k - 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pend.size() > 0 || cyc < next_free) && n < budget) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout cyc=%0d got=%0d want<%0d", cyc, n, budget);
        end
        step(1'b0);
        step(1'b0);
    endtask

    vec_t tv[5];

    initial begin
        int l0, s0, o0, t0, n;
        tv[0] = '{40, 64'h0000_00F4_0000_00F5, 1'b0, 6'b111101, 1, 0, 0};
        tv[1] = '{5,  64'h0000_0000_0000_0016, 1'b0, 6'b000000, 0, 1, 0};
        tv[2] = '{6,  64'h0000_0000_0000_000D, 1'b0, 6'b001101, 1, 0, 0};
        tv[3] = '{12, 64'h0000_0000_0000_0ABC, 1'b0, 6'h2A,     1, 0, 0};
        tv[4] = '{64, 64'hDEAD_BEEF_0123_4567, 1'b1, 6'h37,     1, 0, 1};

        for (int i = 0; i < 3; i++) step(1'b1);
        armed = 1;
        step(1'b0);
        step(1'b0);

        for (int i = 0; i < 5; i++) begin
            l0 = n_load;
            s0 = n_short;
            o0 = n_ovf;
            vprob = (i == 0) ? 67 : 100;
            push_blk(tv[i].k, tv[i].bits, tv[i].nolast);
            drain(2000);
            chk("tv_loads", 32'(n_load - l0), 32'(tv[i].loads));
            chk("tv_shorts", 32'(n_short - s0), 32'(tv[i].shorts));
            chk("tv_ovfs", 32'(n_ovf - o0), 32'(tv[i].ovfs));
            if (tv[i].loads > 0) chk("tv_init", 32'(last_init), 32'(tv[i].init));
        end

        vprob = 100;
        l0 = n_load;
        push_blk(12, 64'h5A3, 1'b0);
        push_blk(12, 64'hC3F, 1'b0);
        drain(2000);
        chk("b2b_loads", 32'(n_load - l0), 32'd2);
        chk("b2b_gap", 32'(last_gap), 32'(2 + GAPC + 12));
        chk("b2b_init", 32'(last_init), 32'h30);

        play_start = -1;
        push_blk(40, {$urandom, $urandom}, 1'b0);
        n = 0;
        while (!(play_start >= 0 && cyc == play_start + 9) && n < 1000) begin
            step(1'b0);
            n++;
        end
        chk("rst_reach_play", 32'(n < 1000), 32'd1);
        t0 = n_last;
        step(1'b1);
        step(1'b0);
        chk("rst_din_valid", 32'(din_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 60; i++) step(1'b0);
        chk("rst_no_last", 32'(n_last - t0), 32'd0);
        t0 = n_last;
        push_blk(20, {$urandom, $urandom}, 1'b0);
        drain(2000);
        chk("post_rst_last", 32'(n_last - t0), 32'd1);

        for (int b = 0; b < 30; b++) begin
            n = $urandom_range(80, 1);
            for (int i = 0; i < n; i++) push_bit(1'($urandom), i == n - 1);
        end
        vprob = 60;
        drain(40000);
        push_blk(10, 64'h2D5, 1'b0);
        vprob = 100;
        drain(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
